mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the five-stage RV64I core, directly downstream of the execute stage. It registers the execute-to-memory bus and takes the synchronous data-SRAM read data that returns one cycle after the execute stage issued the request. It aligns and extends load data, then selects the load result or the execute result. It drives the writeback bus and the memory-to-execute forwarding path, and holds the SRAM read data stable across pipeline stalls.

## Interface
- `EX2MEM_WD`, 182: execute-to-memory bus width: lsu_op 7 + data_ram_sel 8 + sel_mem 1 + rf_we 1 + rf_waddr 5 + ex_result 64 + pc 64 + inst 32.
- `MEM2WB_WD`, 166: memory-to-writeback bus width: rf_we 1 + rf_waddr 5 + rf_wdata 64 + pc 64 + inst 32.
- `MEM2EX_WD`, 70: forwarding bus width: rf_we 1 + rf_waddr 5 + rf_wdata 64.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `stall` in 6: pipeline stall vector; bit 3 is this stage, bit 4 is writeback.
- `stallreq_mem` out 1: stall request; tied 0.
- `ex2mem_bus` in EX2MEM_WD: fields MSB to LSB in the order listed for `EX2MEM_WD`.
- `data_sram_rdata` in 64: SRAM read data, valid only in the cycle after the request.
- `mem2wb_bus` out MEM2WB_WD: {rf_we, rf_waddr, rf_wdata, pc, inst}.
- `mem2ex_fwd` out MEM2EX_WD: {rf_we, rf_waddr, rf_wdata}.
- `mem_excp` out 1: misaligned-load flag.

## Operation
- Input register `bus_r`, updated at the rising edge in this priority:
  - `!rst_n`: load 0.
  - `stall[3] & !stall[4]`: load 0 (bubble).
  - `!stall[3]`: load `ex2mem_bus`.
  - Otherwise: hold.
- `first_r`:
  - Set to 1 on any edge where `bus_r` loads `ex2mem_bus`.
  - Set to 0 on reset, on a bubble, and on every other edge.
- `rdata_hold`: captures `data_sram_rdata` on the edge leaving a cycle in which `first_r`=1.
- Effective read data: `first_r ? data_sram_rdata : rdata_hold`.
- `lsu_op` is one-hot, bits [6:0] = {ld, lwu, lw, lhu, lh, lbu, lb}. An all-zero value means not a load.
- Load alignment:
  - Byte offset k is the index of the lowest set bit of `data_ram_sel`. If `data_ram_sel`=0, k=0.
  - The effective read data is shifted right by 8·k.
  - The result is truncated to 8/16/32/64 bits and then sign-extended (lb, lh, lw) or zero-extended (lbu, lhu, lwu) to 64 bits; ld passes through.
- `rf_wdata = sel_mem ? load_data : ex_result`.
- `rf_we` and `rf_waddr` pass through from `bus_r`. `pc` and `inst` pass through.
- `mem2ex_fwd` carries the same `rf_we`, `rf_waddr` and `rf_wdata` as `mem2wb_bus`.
- An all-zero `bus_r` (reset or bubble) must produce `rf_we`=0 and an all-zero `mem2wb_bus`.

## Timing
- Data-path latency: one register stage. Outputs are combinational from `bus_r`, `first_r`, `rdata_hold` and `data_sram_rdata`.
- SRAM rdata is used live only in the first cycle an instruction occupies this stage. While `stall[3]` holds the stage, `rdata_hold` is used, so output data must not change even if `data_sram_rdata` does.
- Reset values: `bus_r`=0, `first_r`=0, `rdata_hold`=0. All outputs are 0 during and immediately after reset.
- Reset asserted while a load is held: `bus_r` clears at the next edge and the held load is dropped.
- When `stall[3]` and `stall[4]` are both set, the stage holds and `first_r` goes to 0.
- When a new load enters directly behind a held one, `first_r`=1 again and `rdata_hold` is overwritten at the end of that cycle.

## Configuration
- `MEM_MISALIGN_CHK_EN` defined:
  - Checks `data_ram_sel` against the legal patterns for each load width:
    - lb/lbu: exactly one bit set.
    - lh/lhu: 0x03, 0x0C, 0x30 or 0xC0.
    - lw/lwu: 0x0F or 0xF0.
    - ld: 0xFF.
  - On violation: `mem_excp`=1, `rf_we` is forced to 0 on both output buses, and `rf_wdata` is forced to 0.
- Undefined: `mem_excp` is tied 0 and no check logic exists.

## Structure
- Shared package `nova_pkg`: the three bus-width constants, the lsu_op bit indices (LSU_LB=0 … LSU_LD=6), and the legal `data_ram_sel` patterns.
- One combinational sub-module, `mem_load_align`. Inputs: lsu_op, data_ram_sel, rdata (64). Outputs: load_data (64) and misalign (1).
- Top level: the registers, the rdata hold logic, the output muxing and the macro gating.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with a random `ex2mem_bus` → both output buses and `mem_excp` are 0; `rst_n`=1 with no new input → outputs stay 0.
- lb sign extension: lb with `data_ram_sel`=0x04, rdata=0x0000_0000_0080_0000, rd=x5 → `rf_wdata`=0xFFFF_FFFF_FFFF_FF80 and `rf_we`=1. lbu with the same inputs → 0x80.
- lw/lwu: `data_ram_sel`=0xF0, rdata=0x8765_4321_0000_0000 → lw gives 0xFFFF_FFFF_8765_4321; lwu gives 0x0000_0000_8765_4321.
- Stall hold: ld enters with rdata=0x1111…; `stall[3]` and `stall[4]` set for 3 cycles while rdata changes to 0x2222… → `rf_wdata` stays 0x1111_1111_1111_1111 for all 4 cycles.
- Bubble: `stall[3]`=1, `stall[4]`=0 → at the next edge `mem2wb_bus`=0 and `mem2ex_fwd` `rf_we`=0.
- Misaligned load, `MEM_MISALIGN_CHK_EN` defined: lh with `data_ram_sel`=0x06 → `mem_excp`=1, `rf_we`=0. Macro undefined, same stimulus → `mem_excp`=0, `rf_we`=1.

Source files
------------

// File: rtl/nova_pkg.sv
`default_nettype none
// ============================================================================
// nova_pkg : shared widths, lsu_op encoding and legal byte-select patterns
// Revision : 1.0
// ============================================================================
package nova_pkg;

  localparam int EX2MEM_WD = 182;
  localparam int MEM2WB_WD = 166;
  localparam int MEM2EX_WD = 70;

  localparam int LSU_LB  = 0;
  localparam int LSU_LBU = 1;
  localparam int LSU_LH  = 2;
  localparam int LSU_LHU = 3;
  localparam int LSU_LW  = 4;
  localparam int LSU_LWU = 5;
  localparam int LSU_LD  = 6;

  localparam logic [7:0] SEL_H0 = 8'h03;
  localparam logic [7:0] SEL_H1 = 8'h0C;
  localparam logic [7:0] SEL_H2 = 8'h30;
  localparam logic [7:0] SEL_H3 = 8'hC0;
  localparam logic [7:0] SEL_W0 = 8'h0F;
  localparam logic [7:0] SEL_W1 = 8'hF0;
  localparam logic [7:0] SEL_D  = 8'hFF;

  typedef struct packed {
    logic [6:0]  lsu_op;
    logic [7:0]  data_ram_sel;
    logic        sel_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] ex_result;
    logic [63:0] pc;
    logic [31:0] inst;
  } ex2mem_t;

  function automatic logic sel_is_legal(input logic [6:0] op, input logic [7:0] sel);
    logic ok;
    ok = 1'b1;
    if (op[LSU_LB] | op[LSU_LBU])
      ok = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
    else if (op[LSU_LH] | op[LSU_LHU])
      ok = (sel == SEL_H0) || (sel == SEL_H1) || (sel == SEL_H2) || (sel == SEL_H3);
    else if (op[LSU_LW] | op[LSU_LWU])
      ok = (sel == SEL_W0) || (sel == SEL_W1);
    else if (op[LSU_LD])
      ok = (sel == SEL_D);
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// mem_load_align : byte-lane alignment and sign/zero extension of load data
// Revision       : 1.0
// ============================================================================
module mem_load_align
  import nova_pkg::*;
#(
  parameter bit CHK_EN = 1'b0
) (
  input  logic [6:0]  lsu_op,
  input  logic [7:0]  data_ram_sel,
  input  logic [63:0] rdata,
  output logic [63:0] load_data,
  output logic        misalign
);

  logic [2:0]  byte_ofs;
  logic [63:0] shifted;

  // Descending scan so the lowest set select bit wins.
  always_comb begin
    byte_ofs = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (data_ram_sel[i]) byte_ofs = 3'(i);
    end
  end

  assign shifted = rdata >> {byte_ofs, 3'b000};

  always_comb begin
    load_data = 64'h0;
    if (lsu_op[LSU_LD])       load_data = shifted;
    else if (lsu_op[LSU_LW])  load_data = {{32{shifted[31]}}, shifted[31:0]};
    else if (lsu_op[LSU_LWU]) load_data = {32'h0, shifted[31:0]};
    else if (lsu_op[LSU_LH])  load_data = {{48{shifted[15]}}, shifted[15:0]};
    else if (lsu_op[LSU_LHU]) load_data = {48'h0, shifted[15:0]};
    else if (lsu_op[LSU_LB])  load_data = {{56{shifted[7]}}, shifted[7:0]};
    else if (lsu_op[LSU_LBU]) load_data = {56'h0, shifted[7:0]};
  end

  generate
    if (CHK_EN) begin : g_chk
      assign misalign = (lsu_op != 7'h00) && !sel_is_legal(lsu_op, data_ram_sel);
    end else begin : g_nochk
      assign misalign = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : RV64I memory-access stage (input register, rdata hold, load mux)
//             MEM_MISALIGN_CHK_EN enables the misaligned-load exception.
// Revision  : 1.0
// ============================================================================
module mem_stage
  import nova_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           stall,
  output logic                 stallreq_mem,
  input  logic [EX2MEM_WD-1:0] ex2mem_bus,
  input  logic [63:0]          data_sram_rdata,
  output logic [MEM2WB_WD-1:0] mem2wb_bus,
  output logic [MEM2EX_WD-1:0] mem2ex_fwd,
  output logic                 mem_excp
);

`ifdef MEM_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  ex2mem_t     bus_r;
  logic        first_r;
  logic [63:0] rdata_hold;
  logic [63:0] rdata_eff;
  logic [63:0] load_data;
  logic        misalign;
  logic        rf_we;
  logic [63:0] rf_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_r   <= '0;
      first_r <= 1'b0;
    end else if (stall[3] && !stall[4]) begin
      bus_r   <= '0;
      first_r <= 1'b0;
    end else if (!stall[3]) begin
      bus_r   <= ex2mem_t'(ex2mem_bus);
      first_r <= 1'b1;
    end else begin
      first_r <= 1'b0;
    end
  end

  // SRAM data is only valid in the first cycle; keep a copy for stalls.
  always_ff @(posedge clk) begin
    if (!rst_n)       rdata_hold <= 64'h0;
    else if (first_r) rdata_hold <= data_sram_rdata;
  end

  assign rdata_eff = first_r ? data_sram_rdata : rdata_hold;

  mem_load_align #(
    .CHK_EN (CHK_EN)
  ) u_align (
    .lsu_op       (bus_r.lsu_op),
    .data_ram_sel (bus_r.data_ram_sel),
    .rdata        (rdata_eff),
    .load_data    (load_data),
    .misalign     (misalign)
  );

  assign rf_we    = bus_r.rf_we & ~misalign;
  assign rf_wdata = misalign ? 64'h0 : (bus_r.sel_mem ? load_data : bus_r.ex_result);

  assign mem2wb_bus   = {rf_we, bus_r.rf_waddr, rf_wdata, bus_r.pc, bus_r.inst};
  assign mem2ex_fwd   = {rf_we, bus_r.rf_waddr, rf_wdata};
  assign mem_excp     = misalign;
  assign stallreq_mem = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : vector table + scoreboard bench for mem_stage
// Revision     : 1.0
// ============================================================================
module tb_mem_stage;
  import nova_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [5:0]           stall;
  logic                 stallreq_mem;
  logic [EX2MEM_WD-1:0] ex2mem_bus;
  logic [63:0]          data_sram_rdata;
  logic [MEM2WB_WD-1:0] mem2wb_bus;
  logic [MEM2EX_WD-1:0] mem2ex_fwd;
  logic                 mem_excp;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .stallreq_mem    (stallreq_mem),
    .ex2mem_bus      (ex2mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem2wb_bus      (mem2wb_bus),
    .mem2ex_fwd      (mem2ex_fwd),
    .mem_excp        (mem_excp)
  );

  localparam logic [6:0] OP_LB = 7'h01, OP_LBU = 7'h02, OP_LH = 7'h04, OP_LHU = 7'h08;
  localparam logic [6:0] OP_LW = 7'h10, OP_LWU = 7'h20, OP_LD = 7'h40, OP_NONE = 7'h00;

  typedef struct {
    logic [6:0]  op;
    logic [7:0]  sel;
    logic        sm;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] exr;
    logic [63:0] rdata;
    logic [63:0] wd;
    logic        ewe;
    logic        exc;
  } vec_t;

  typedef struct {
    logic [MEM2WB_WD-1:0] wb;
    logic [MEM2EX_WD-1:0] fwd;
    logic                 exc;
  } exp_t;

  vec_t v[12];
  exp_t sb[$];
  exp_t e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [165:0] act, input logic [165:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EX2MEM_WD-1:0] mk(input vec_t x, input int i);
    return {x.op, x.sel, x.sm, x.we, x.rd, x.exr, 64'h8000_0000 + 64'(i) * 4, 32'h0001_0013 + 32'(i)};
  endfunction

  function automatic exp_t mke(input vec_t x, input int i);
    exp_t r;
    r.wb  = {x.ewe, x.rd, x.wd, 64'h8000_0000 + 64'(i) * 4, 32'h0001_0013 + 32'(i)};
    r.fwd = {x.ewe, x.rd, x.wd};
    r.exc = x.exc;
    return r;
  endfunction

  function automatic logic [EX2MEM_WD-1:0] ld_bus(input logic [4:0] rd);
    return {OP_LD, 8'hFF, 1'b1, 1'b1, rd, 64'h0BAD_0BAD_0BAD_0BAD, 64'h0000_0000_8000_1000, 32'h0000_3003};
  endfunction

  initial begin
    v[0]  = '{OP_LB,   8'h04, 1, 1, 5'd5,  64'h0, 64'h0000_0000_0080_0000, 64'hFFFF_FFFF_FFFF_FF80, 1, 0};
    v[1]  = '{OP_LBU,  8'h04, 1, 1, 5'd5,  64'h0, 64'h0000_0000_0080_0000, 64'h0000_0000_0000_0080, 1, 0};
    v[2]  = '{OP_LW,   8'hF0, 1, 1, 5'd6,  64'h0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 1, 0};
    v[3]  = '{OP_LWU,  8'hF0, 1, 1, 5'd6,  64'h0, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 1, 0};
    v[4]  = '{OP_LH,   8'h0C, 1, 1, 5'd7,  64'h0, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 1, 0};
    v[5]  = '{OP_LHU,  8'hC0, 1, 1, 5'd8,  64'h0, 64'hFFFE_0000_0000_0000, 64'h0000_0000_0000_FFFE, 1, 0};
    v[6]  = '{OP_LD,   8'hFF, 1, 1, 5'd9,  64'h0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1, 0};
    v[7]  = '{OP_NONE, 8'h00, 0, 1, 5'd10, 64'hDEAD_BEEF_CAFE_F00D, 64'h5555_AAAA_5555_AAAA, 64'hDEAD_BEEF_CAFE_F00D, 1, 0};
    v[8]  = '{OP_LB,   8'h80, 1, 1, 5'd11, 64'h0, 64'h7F00_0000_0000_00FF, 64'h0000_0000_0000_007F, 1, 0};
`ifdef MEM_MISALIGN_CHK_EN
    v[9]  = '{OP_LH,   8'h06, 1, 1, 5'd12, 64'h0, 64'h0000_0000_00AB_CD00, 64'h0, 0, 1};
`else
    v[9]  = '{OP_LH,   8'h06, 1, 1, 5'd12, 64'h0, 64'h0000_0000_00AB_CD00, 64'hFFFF_FFFF_FFFF_ABCD, 1, 0};
`endif
    v[10] = '{OP_NONE, 8'h00, 0, 0, 5'd13, 64'h0000_0000_0000_0005, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0005, 0, 0};
    v[11] = '{OP_LW,   8'h0F, 1, 1, 5'd14, 64'h0, 64'hFFFF_FFFF_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, 1, 0};

    // Reset with garbage on the input bus.
    rst_n           = 1'b0;
    stall           = 6'b0;
    ex2mem_bus      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    data_sram_rdata = {$urandom, $urandom};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb",   mem2wb_bus, '0);
    chk("rst_fwd",  166'(mem2ex_fwd), '0);
    chk("rst_excp", 166'(mem_excp), '0);
    chk("rst_sreq", 166'(stallreq_mem), '0);
    ex2mem_bus = '0;
    rst_n      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_wb",  mem2wb_bus, '0);
    chk("post_rst_fwd", 166'(mem2ex_fwd), '0);

    // Back-to-back table vectors through the scoreboard.
    ex2mem_bus = mk(v[0], 0);
    sb.push_back(mke(v[0], 0));
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      data_sram_rdata = v[i].rdata;
      if (i < 11) begin
        ex2mem_bus = mk(v[i+1], i + 1);
        sb.push_back(mke(v[i+1], i + 1));
      end else begin
        ex2mem_bus = '0;
      end
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("vec%0d_wb", i),   mem2wb_bus, e.wb);
      chk($sformatf("vec%0d_fwd", i),  166'(mem2ex_fwd), 166'(e.fwd));
      chk($sformatf("vec%0d_excp", i), 166'(mem_excp), 166'(e.exc));
    end

    // Stall hold: SRAM data changes while the stage is frozen.
    @(negedge clk);
    ex2mem_bus = ld_bus(5'd20);
    @(posedge clk);
    #1;
    data_sram_rdata = 64'h1111_1111_1111_1111;
    stall           = 6'b011000;
    ex2mem_bus      = ld_bus(5'd21);
    @(negedge clk);
    chk("hold0", 166'(mem2wb_bus[159:96]), 166'(64'h1111_1111_1111_1111));
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      data_sram_rdata = 64'h2222_2222_2222_2222;
      @(negedge clk);
      chk($sformatf("hold%0d", c), 166'(mem2wb_bus[159:96]), 166'(64'h1111_1111_1111_1111));
    end

    // New load directly behind the held one, then hold it too.
    stall = 6'b0;
    @(posedge clk);
    #1;
    data_sram_rdata = 64'h3333_3333_3333_3333;
    stall           = 6'b011000;
    @(negedge clk);
    chk("next_ld",  166'(mem2wb_bus[159:96]), 166'(64'h3333_3333_3333_3333));
    chk("next_rd",  166'(mem2wb_bus[164:160]), 166'(5'd21));
    @(posedge clk);
    #1;
    data_sram_rdata = 64'h4444_4444_4444_4444;
    @(negedge clk);
    chk("next_hold", 166'(mem2wb_bus[159:96]), 166'(64'h3333_3333_3333_3333));

    // Bubble.
    stall = 6'b001000;
    @(posedge clk);
    @(negedge clk);
    chk("bubble_wb", mem2wb_bus, '0);
    chk("bubble_we", 166'(mem2ex_fwd[69]), '0);

    // Reset arriving while a load is held.
    stall      = 6'b0;
    ex2mem_bus = ld_bus(5'd22);
    @(posedge clk);
    #1;
    data_sram_rdata = 64'h5555_5555_5555_5555;
    stall           = 6'b011000;
    @(negedge clk);
    chk("pre_rst_ld", 166'(mem2wb_bus[159:96]), 166'(64'h5555_5555_5555_5555));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_drop_wb",  mem2wb_bus, '0);
    chk("rst_drop_fwd", 166'(mem2ex_fwd), '0);
    rst_n = 1'b1;
    stall = 6'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
